// File: rtl/multicycle_ctrl.sv
// Multicycle fetch/decode/execute controller: drives the PC mux, register-file
// addresses, ALU opcode and write strobe, and counts retired instructions.
module multicycle_ctrl #(
  parameter int IW   = 16,
  parameter int OPW  = 5,
  parameter int RAW  = 4,
  parameter int OFFW = 10,
  parameter int CNTW = 16,
  parameter logic [OPW-1:0] OP_NOP  = '0,
  parameter logic [OPW-1:0] OP_BR   = 5'h10,
  parameter logic [OPW-1:0] OP_BZ   = 5'h11,
  parameter logic [OPW-1:0] OP_ST   = 5'h18,
  parameter logic [OPW-1:0] OP_HALT = 5'h1F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   imem_data,
  input  logic            imem_ready,
  output logic            imem_req,
  input  logic            stall,
  input  logic            zero_flag,
  output logic            en_pc_2,
  output logic            pc_inc,
  output logic            branch_en,
  output logic [OFFW-1:0] pc_offset,
  output logic [RAW-1:0]  src_reg,
  output logic [RAW-1:0]  dst_reg,
  output logic [RAW-1:0]  wr_reg,
  output logic [OPW-1:0]  op_code,
  output logic            wr_en,
  output logic [5:0]      fsm_state,
  output logic            halted,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [5:0] {
    S_FETCH  = 6'b000001,
    S_DECODE = 6'b000010,
    S_READ   = 6'b000100,
    S_EXEC   = 6'b001000,
    S_WB     = 6'b010000,
    S_HALT   = 6'b100000
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] ir;
  logic          ir_load;
  logic          ret_inc;

  assign op_code   = ir[IW-1 -: OPW];
  assign dst_reg   = ir[IW-OPW-1 -: RAW];
  assign src_reg   = ir[IW-OPW-RAW-1 -: RAW];
  assign wr_reg    = dst_reg;
  assign pc_offset = ir[OFFW-1:0];
  assign fsm_state = state;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (ir_load) ir <= imem_data;
      if (ret_inc) retired <= retired + CNTW'(1);
    end
  end

  // Every transition and strobe is gated by stall, so a stalled cycle is a no-op.
  always_comb begin
    state_n   = state;
    ir_load   = 1'b0;
    ret_inc   = 1'b0;
    imem_req  = 1'b0;
    pc_inc    = 1'b0;
    en_pc_2   = 1'b0;
    branch_en = 1'b0;
    wr_en     = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready && !stall) begin
          ir_load = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!stall) begin
          pc_inc  = 1'b1;
          en_pc_2 = 1'b1;
          if (op_code == OP_HALT) begin
            state_n = S_HALT;
          end else if (op_code == OP_NOP) begin
            state_n = S_FETCH;
            ret_inc = 1'b1;
          end else begin
            state_n = S_READ;
          end
        end
      end
      S_READ: begin
        if (!stall) state_n = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          if (op_code == OP_BR || (op_code == OP_BZ && zero_flag)) begin
            branch_en = 1'b1;
            pc_inc    = 1'b1;
            state_n   = S_FETCH;
            ret_inc   = 1'b1;
          end else if (op_code == OP_BZ || op_code == OP_ST) begin
            state_n = S_FETCH;
            ret_inc = 1'b1;
          end else begin
            state_n = S_WB;
          end
        end
      end
      S_WB: begin
        if (!stall) begin
          wr_en   = 1'b1;
          state_n = S_FETCH;
          ret_inc = 1'b1;
        end
      end
      S_HALT: state_n = S_HALT;
      // Upset recovery: any non-one-hot code falls back to FETCH.
      default: state_n = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl plus hand-written
// sequences for reset abort, halt and counter wrap.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_data = '0;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        zero_flag = 1'b0;
  logic        imem_req, en_pc_2, pc_inc, branch_en, wr_en, halted;
  logic [9:0]  pc_offset;
  logic [3:0]  src_reg, dst_reg, wr_reg;
  logic [4:0]  op_code;
  logic [5:0]  fsm_state;
  logic [15:0] retired;

  // Small-counter instance used only for the wrap check.
  logic [15:0] data4 = '0;
  logic        rdy4 = 1'b0;
  logic        w_req, w_en_pc_2, w_pc_inc, w_branch_en, w_wr_en, w_halted;
  logic [9:0]  w_pc_offset;
  logic [3:0]  w_src, w_dst, w_wr;
  logic [4:0]  w_op;
  logic [5:0]  w_state;
  logic [3:0]  w_retired;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .imem_data(imem_data), .imem_ready(imem_ready),
    .imem_req(imem_req), .stall(stall), .zero_flag(zero_flag),
    .en_pc_2(en_pc_2), .pc_inc(pc_inc), .branch_en(branch_en),
    .pc_offset(pc_offset), .src_reg(src_reg), .dst_reg(dst_reg),
    .wr_reg(wr_reg), .op_code(op_code), .wr_en(wr_en),
    .fsm_state(fsm_state), .halted(halted), .retired(retired)
  );

  multicycle_ctrl #(.CNTW(4)) dut4 (
    .clk(clk), .rst(rst), .imem_data(data4), .imem_ready(rdy4),
    .imem_req(w_req), .stall(stall), .zero_flag(zero_flag),
    .en_pc_2(w_en_pc_2), .pc_inc(w_pc_inc), .branch_en(w_branch_en),
    .pc_offset(w_pc_offset), .src_reg(w_src), .dst_reg(w_dst),
    .wr_reg(w_wr), .op_code(w_op), .wr_en(w_wr_en),
    .fsm_state(w_state), .halted(w_halted), .retired(w_retired)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        rdy;
    logic        stl;
    logic        zf;
    logic [5:0]  st;
    logic        req;
    logic [3:0]  strb;   // {pc_inc, en_pc_2, branch_en, wr_en}
    logic [4:0]  op;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] d, input logic r, input logic s, input logic z,
                     input logic [5:0] st, input logic rq, input logic [3:0] sb,
                     input logic [4:0] op, input logic [15:0] ret);
    vec_t v;
    v = '{d, r, s, z, st, rq, sb, op, ret};
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ready = 1'b0;
    stall = 1'b0;
    zero_flag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //   data     rdy  stl  zf  state    req  strb     op     ret
    add(16'h1234, 1, 0, 0, 6'h01, 1, 4'b0000, 5'h00, 0); // ALU fetch
    add(16'h0000, 0, 0, 0, 6'h02, 0, 4'b1100, 5'h02, 0);
    add(16'h0000, 1, 0, 0, 6'h04, 0, 4'b0000, 5'h02, 0); // ready ignored
    add(16'h0000, 0, 0, 0, 6'h08, 0, 4'b0000, 5'h02, 0);
    add(16'h0000, 0, 0, 0, 6'h10, 0, 4'b0001, 5'h02, 0);
    add(16'h0000, 0, 0, 0, 6'h01, 1, 4'b0000, 5'h02, 1); // wait states
    add(16'h0000, 0, 0, 0, 6'h01, 1, 4'b0000, 5'h02, 1);
    add(16'h0000, 0, 0, 0, 6'h01, 1, 4'b0000, 5'h02, 1);
    add(16'h8BF0, 1, 0, 0, 6'h01, 1, 4'b0000, 5'h02, 1); // BZ taken
    add(16'h1234, 1, 0, 0, 6'h02, 0, 4'b1100, 5'h11, 1);
    add(16'h1234, 1, 0, 0, 6'h04, 0, 4'b0000, 5'h11, 1);
    add(16'h0000, 0, 0, 1, 6'h08, 0, 4'b1010, 5'h11, 1);
    add(16'h8BF0, 1, 0, 0, 6'h01, 1, 4'b0000, 5'h11, 2); // BZ not taken
    add(16'h0000, 0, 0, 1, 6'h02, 0, 4'b1100, 5'h11, 2);
    add(16'h0000, 0, 0, 0, 6'h04, 0, 4'b0000, 5'h11, 2);
    add(16'h0000, 0, 0, 0, 6'h08, 0, 4'b0000, 5'h11, 2);
    add(16'h1234, 1, 0, 0, 6'h01, 1, 4'b0000, 5'h11, 3); // ALU, stall in WB
    add(16'h0000, 0, 0, 0, 6'h02, 0, 4'b1100, 5'h02, 3);
    add(16'h0000, 0, 0, 0, 6'h04, 0, 4'b0000, 5'h02, 3);
    add(16'h0000, 0, 0, 0, 6'h08, 0, 4'b0000, 5'h02, 3);
    add(16'h0000, 0, 1, 0, 6'h10, 0, 4'b0000, 5'h02, 3);
    add(16'h0000, 0, 1, 0, 6'h10, 0, 4'b0000, 5'h02, 3);
    add(16'h0000, 0, 0, 0, 6'h10, 0, 4'b0001, 5'h02, 3);
    add(16'h0000, 0, 0, 0, 6'h01, 1, 4'b0000, 5'h02, 4);
    add(16'h0000, 0, 0, 0, 6'h01, 1, 4'b0000, 5'h02, 4);
    add(16'hC000, 1, 1, 0, 6'h01, 1, 4'b0000, 5'h02, 4); // stall blocks fetch
    add(16'h0000, 0, 0, 0, 6'h01, 1, 4'b0000, 5'h02, 4);
    add(16'hC000, 1, 0, 0, 6'h01, 1, 4'b0000, 5'h02, 4); // store
    add(16'h0000, 0, 0, 0, 6'h02, 0, 4'b1100, 5'h18, 4);
    add(16'h0000, 0, 0, 0, 6'h04, 0, 4'b0000, 5'h18, 4);
    add(16'h0000, 0, 0, 1, 6'h08, 0, 4'b0000, 5'h18, 4);
    add(16'h0000, 1, 0, 0, 6'h01, 1, 4'b0000, 5'h18, 5); // NOP, stall in DECODE
    add(16'h0000, 0, 1, 0, 6'h02, 0, 4'b0000, 5'h00, 5);
    add(16'h0000, 0, 0, 0, 6'h02, 0, 4'b1100, 5'h00, 5);
    add(16'h0000, 0, 0, 0, 6'h01, 1, 4'b0000, 5'h00, 6);

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    check("rst_state", 32'(fsm_state), 32'h01);
    check("rst_strobes", 32'({pc_inc, en_pc_2, branch_en, wr_en}), 32'h0);
    check("rst_retired", 32'(retired), 32'h0);
    check("rst_op", 32'(op_code), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      imem_data  = vecs[i].data;
      imem_ready = vecs[i].rdy;
      stall      = vecs[i].stl;
      zero_flag  = vecs[i].zf;
      #2;
      check($sformatf("row%0d_state", i), 32'(fsm_state), 32'(vecs[i].st));
      check($sformatf("row%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      check($sformatf("row%0d_strobes", i), 32'({pc_inc, en_pc_2, branch_en, wr_en}), 32'(vecs[i].strb));
      check($sformatf("row%0d_op", i), 32'(op_code), 32'(vecs[i].op));
      check($sformatf("row%0d_retired", i), 32'(retired), 32'(vecs[i].ret));
      if (i == 4) begin
        check("alu_wr_reg", 32'(wr_reg), 32'h4);
        check("alu_dst_reg", 32'(dst_reg), 32'h4);
        check("alu_src_reg", 32'(src_reg), 32'h6);
      end
      if (i == 11) check("bz_pc_offset", 32'(pc_offset), 32'h3F0);
    end

    // Reset during EXEC aborts the instruction
    do_reset();
    imem_data = 16'h1234;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("abort_in_exec", 32'(fsm_state), 32'h08);
    rst = 1'b1;
    #1;
    check("abort_state", 32'(fsm_state), 32'h01);
    check("abort_retired", 32'(retired), 32'h0);
    begin
      int pulses = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        rst = 1'b0;
        #2;
        if (wr_en) pulses++;
      end
      check("abort_wr_pulses", 32'(pulses), 32'h0);
      check("abort_retired_after", 32'(retired), 32'h0);
      check("abort_state_after", 32'(fsm_state), 32'h01);
    end

    // HALT is absorbing and not counted
    do_reset();
    imem_data = 16'hF800;
    imem_ready = 1'b1;
    @(negedge clk);
    imem_data = 16'h1234;
    #2;
    check("halt_decode", 32'(fsm_state), 32'h02);
    @(negedge clk);
    #2;
    check("halt_state", 32'(fsm_state), 32'h20);
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_req", 32'(imem_req), 32'h0);
    begin
      int bad = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        imem_ready = k[0];
        zero_flag  = k[1];
        #2;
        if (fsm_state != 6'h20 || !halted || imem_req ||
            {pc_inc, en_pc_2, branch_en, wr_en} != 4'b0) bad++;
      end
      check("halt_hold_bad_cycles", 32'(bad), 32'h0);
      check("halt_retired", 32'(retired), 32'h0);
    end

    // Counter wrap with CNTW = 4: 16 NOPs -> 0, 17 NOPs -> 1
    do_reset();
    data4 = 16'h0000;
    rdy4 = 1'b1;
    repeat (30) @(negedge clk);
    #2;
    check("wrap_15", 32'(w_retired), 32'hF);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("wrap_16", 32'(w_retired), 32'h0);
    @(negedge clk);
    rdy4 = 1'b0;
    @(negedge clk);
    #2;
    check("wrap_17", 32'(w_retired), 32'h1);
    check("wrap_state", 32'(w_state), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
